// File: rtl/divider_pkg.sv
// Shared FSM encoding and counter sizing for the taint-tracking word divider.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } div_state_e;

  localparam int unsigned DefaultWidth = 32;

  // The iteration counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DefaultCntW = cnt_width(DefaultWidth);

endpackage

// File: rtl/divider_datapath_taint_track_word.sv
// Restoring shift-subtract datapath plus control/data taint registers and held results.
module divider_datapath_taint_track_word #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idle,
  input  logic             load,
  input  logic             run,
  input  logic             done,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic             quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic             remainder_t,
  output logic             divByZero,
  output logic             divByZero_t,
  output logic             quotientDone_t
);

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             ctrl_t_q;
  logic             op_t_q;
  logic             dvs_t_q;

  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dbz_q;
  logic             res_t_q;
  logic             dbz_t_q;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] quo_sh;

  // Top bit of rem_q is always zero between steps, so diff's MSB is a clean sign.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {2'b00, dvs_q};
    fits   = ~diff[WIDTH+1];
    quo_sh = {quo_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      ctrl_t_q <= 1'b0;
      op_t_q   <= 1'b0;
      dvs_t_q  <= 1'b0;
    end else begin
      if (idle) begin
        ctrl_t_q <= start_t;
      end
      if (load) begin
        rem_q   <= '0;
        quo_q   <= dividend;
        dvs_q   <= divisor;
        op_t_q  <= dividend_t | divisor_t;
        dvs_t_q <= divisor_t;
      end else if (run) begin
        rem_q <= fits ? diff[WIDTH:0] : rem_sh[WIDTH:0];
        quo_q <= {quo_sh[WIDTH-1:1], fits};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      res_t_q   <= 1'b0;
      dbz_t_q   <= 1'b0;
    end else if (done) begin
      quo_out_q <= quo_q;
      rem_out_q <= rem_q[WIDTH-1:0];
      dbz_q     <= (dvs_q == '0);
      res_t_q   <= op_t_q | ctrl_t_q;
      dbz_t_q   <= dvs_t_q | ctrl_t_q;
    end
  end

  // Results are visible during the DONE cycle itself and held afterwards.
  always_comb begin
    quotient       = done ? quo_q : quo_out_q;
    remainder      = done ? rem_q[WIDTH-1:0] : rem_out_q;
    divByZero      = done ? (dvs_q == '0) : dbz_q;
    quotient_t     = done ? (op_t_q | ctrl_t_q) : res_t_q;
    remainder_t    = quotient_t;
    divByZero_t    = done ? (dvs_t_q | ctrl_t_q) : dbz_t_q;
    quotientDone_t = ctrl_t_q;
  end

endmodule

// File: rtl/divider_taint_track_word.sv
// Unsigned restoring divider with fixed WIDTH+2 cycle latency and taint propagation.
module divider_taint_track_word
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic             quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic             remainder_t,
  output logic             quotientDone,
  output logic             quotientDone_t,
  output logic             divByZero,
  output logic             divByZero_t
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = CntW'(WIDTH);
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign quotientDone = (state_q == StDone);

  divider_datapath_taint_track_word #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk            (clk),
    .rst            (rst),
    .idle           (state_q == StIdle),
    .load           (state_q == StLoad),
    .run            (state_q == StRun),
    .done           (state_q == StDone),
    .start_t        (start_t),
    .dividend       (dividend),
    .dividend_t     (dividend_t),
    .divisor        (divisor),
    .divisor_t      (divisor_t),
    .quotient       (quotient),
    .quotient_t     (quotient_t),
    .remainder      (remainder),
    .remainder_t    (remainder_t),
    .divByZero      (divByZero),
    .divByZero_t    (divByZero_t),
    .quotientDone_t (quotientDone_t)
  );

endmodule

// File: tb/tb_divider_taint_track_word.sv
// Randomised and directed bench for divider_taint_track_word at WIDTH=8.
module tb_divider_taint_track_word;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start, start_t;
  logic [W-1:0] dividend, divisor;
  logic         dividend_t, divisor_t;
  logic [W-1:0] quotient, remainder;
  logic         quotient_t, remainder_t;
  logic         quotientDone, quotientDone_t;
  logic         divByZero, divByZero_t;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_q, prev_r;

  typedef struct {
    logic [W-1:0] q, r, mq, mr;
    logic         dbz, qt, rt, dzt, dnt;
    int           cyc, pulses;
  } obs_t;

  divider_taint_track_word #(
    .WIDTH(W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_t        (start_t),
    .dividend       (dividend),
    .dividend_t     (dividend_t),
    .divisor        (divisor),
    .divisor_t      (divisor_t),
    .quotient       (quotient),
    .quotient_t     (quotient_t),
    .remainder      (remainder),
    .remainder_t    (remainder_t),
    .quotientDone   (quotientDone),
    .quotientDone_t (quotientDone_t),
    .divByZero      (divByZero),
    .divByZero_t    (divByZero_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(a % b);
  endfunction

  // Issues one start from IDLE and watches 30 cycles; cycle 1 is the one after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic at, input logic bt, input logic st, output obs_t o);
    o.q = '0; o.r = '0; o.mq = '0; o.mr = '0;
    o.dbz = 0; o.qt = 0; o.rt = 0; o.dzt = 0; o.dnt = 0;
    o.cyc = 0; o.pulses = 0;
    dividend = a; divisor = b; dividend_t = at; divisor_t = bt;
    start = 1'b1; start_t = st;
    @(posedge clk);
    #1 start = 1'b0; start_t = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 5) begin
        o.mq = quotient;
        o.mr = remainder;
      end
      if (quotientDone === 1'b1) begin
        o.pulses++;
        if (o.pulses == 1) begin
          o.cyc = c; o.q = quotient; o.r = remainder; o.dbz = divByZero;
          o.qt = quotient_t; o.rt = remainder_t; o.dzt = divByZero_t; o.dnt = quotientDone_t;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start_t = 1'b1;
    dividend = 8'd100; divisor = 8'd7; dividend_t = 1'b1; divisor_t = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({quotient, remainder, divByZero, quotientDone, quotient_t, remainder_t,
         divByZero_t, quotientDone_t} !== '0) begin
      bad++;
      $display("FAIL reset_state: q=%0d r=%0d dbz=%b done=%b t=%b%b%b%b want all 0",
               quotient, remainder, divByZero, quotientDone,
               quotient_t, remainder_t, divByZero_t, quotientDone_t);
    end
    @(posedge clk);
    #1 start = 1'b0; start_t = 1'b0; dividend_t = 1'b0; divisor_t = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    obs_t o;
    launch(8'd100, 8'd7, 1'b0, 1'b0, 1'b0, o);
    total++;
    if (o.q !== 8'd14 || o.r !== 8'd2 || o.dbz !== 1'b0) begin
      bad++;
      $display("FAIL div_100_7: q=%0d r=%0d dbz=%b want 14 2 0", o.q, o.r, o.dbz);
    end
    total++;
    if (o.cyc != 10 || o.pulses != 1) begin
      bad++;
      $display("FAIL timing_100_7: cycle=%0d pulses=%0d want 10 1", o.cyc, o.pulses);
    end
    total++;
    if ({o.qt, o.rt, o.dzt, o.dnt} !== 4'b0000) begin
      bad++;
      $display("FAIL taint_100_7: t=%b%b%b%b want 0000", o.qt, o.rt, o.dzt, o.dnt);
    end

    launch(8'd37, 8'd0, 1'b0, 1'b0, 1'b0, o);
    total++;
    if (o.q !== 8'hFF || o.r !== 8'd37 || o.dbz !== 1'b1) begin
      bad++;
      $display("FAIL div_by_zero: q=%0h r=%0d dbz=%b want ff 37 1", o.q, o.r, o.dbz);
    end
    total++;
    if (o.cyc != 10 || o.pulses != 1) begin
      bad++;
      $display("FAIL timing_div0: cycle=%0d pulses=%0d want 10 1", o.cyc, o.pulses);
    end
    total++;
    if (o.mq !== 8'd14 || o.mr !== 8'd2) begin
      bad++;
      $display("FAIL hold_mid_run: q=%0d r=%0d want 14 2", o.mq, o.mr);
    end

    launch(8'd200, 8'd9, 1'b1, 1'b0, 1'b0, o);
    total++;
    if (o.q !== 8'd22 || o.r !== 8'd2 || o.dbz !== 1'b0) begin
      bad++;
      $display("FAIL div_200_9: q=%0d r=%0d dbz=%b want 22 2 0", o.q, o.r, o.dbz);
    end
    total++;
    if ({o.qt, o.rt, o.dzt, o.dnt} !== 4'b1100) begin
      bad++;
      $display("FAIL taint_200_9: t=%b%b%b%b want 1100", o.qt, o.rt, o.dzt, o.dnt);
    end
    prev_q = 8'd22;
    prev_r = 8'd2;
  endtask

  task automatic test_ctrl_taint();
    obs_t o;
    start = 1'b0; start_t = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (quotientDone_t !== 1'b1) begin
      bad++;
      $display("FAIL idle_ctrl_taint: done_t=%b want 1", quotientDone_t);
    end
    @(posedge clk);
    #1 start_t = 1'b0;
    launch(8'd255, 8'd1, 1'b0, 1'b0, 1'b0, o);
    total++;
    if (o.q !== 8'd255 || o.r !== 8'd0 || {o.qt, o.rt, o.dzt, o.dnt} !== 4'b0000) begin
      bad++;
      $display("FAIL clean_start_255_1: q=%0d r=%0d t=%b%b%b%b want 255 0 0000",
               o.q, o.r, o.qt, o.rt, o.dzt, o.dnt);
    end
    launch(8'd255, 8'd1, 1'b0, 1'b0, 1'b1, o);
    total++;
    if (o.q !== 8'd255 || o.r !== 8'd0 || {o.qt, o.rt, o.dzt, o.dnt} !== 4'b1111) begin
      bad++;
      $display("FAIL tainted_start_255_1: q=%0d r=%0d t=%b%b%b%b want 255 0 1111",
               o.q, o.r, o.qt, o.rt, o.dzt, o.dnt);
    end
    prev_q = 8'd255;
    prev_r = 8'd0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [W-1:0] a, b;
    logic at, bt, st;
    logic [W-1:0] eq, er;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 5) == 0) b = a + W'($urandom_range(1, 3));
      at = 1'($urandom); bt = 1'($urandom); st = 1'($urandom);
      eq = ref_q(a, b);
      er = ref_r(a, b);
      launch(a, b, at, bt, st, o);
      total++;
      if (o.q !== eq || o.r !== er || o.dbz !== (b == 0)) begin
        bad++;
        $display("FAIL rand_result %0d/%0d: q=%0d r=%0d dbz=%b want %0d %0d %b",
                 a, b, o.q, o.r, o.dbz, eq, er, (b == 0));
      end
      total++;
      if ({o.qt, o.rt, o.dzt, o.dnt} !== {at | bt | st, at | bt | st, bt | st, st}) begin
        bad++;
        $display("FAIL rand_taint at=%b bt=%b st=%b: t=%b%b%b%b want %b%b%b%b", at, bt, st,
                 o.qt, o.rt, o.dzt, o.dnt, at | bt | st, at | bt | st, bt | st, st);
      end
      total++;
      if (o.cyc != 10 || o.pulses != 1) begin
        bad++;
        $display("FAIL rand_timing: cycle=%0d pulses=%0d want 10 1", o.cyc, o.pulses);
      end
      total++;
      if (o.mq !== prev_q || o.mr !== prev_r) begin
        bad++;
        $display("FAIL rand_hold: q=%0d r=%0d want %0d %0d", o.mq, o.mr, prev_q, prev_r);
      end
      prev_q = eq;
      prev_r = er;
    end
  endtask

  task automatic test_restart_ignored();
    int pulses = 0;
    int cyc = 0;
    logic [W-1:0] q = '0, r = '0;
    logic dnt = 1'b0, qt = 1'b0;
    dividend = 8'd100; divisor = 8'd7; dividend_t = 1'b0; divisor_t = 1'b0;
    start = 1'b1; start_t = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (quotientDone === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          cyc = c; q = quotient; r = remainder; dnt = quotientDone_t; qt = quotient_t;
        end
      end
      @(posedge clk);
      #1;
      if (c == 3) begin
        start = 1'b1; start_t = 1'b1; dividend = 8'd3; divisor = 8'd1;
      end else if (c == 4) begin
        start = 1'b0; start_t = 1'b0;
      end
    end
    total++;
    if (pulses != 1 || cyc != 10) begin
      bad++;
      $display("FAIL restart_timing: pulses=%0d cycle=%0d want 1 10", pulses, cyc);
    end
    total++;
    if (q !== 8'd14 || r !== 8'd2 || dnt !== 1'b0 || qt !== 1'b0) begin
      bad++;
      $display("FAIL restart_result: q=%0d r=%0d done_t=%b q_t=%b want 14 2 0 0",
               q, r, dnt, qt);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    obs_t o;
    dividend = 8'd50; divisor = 8'd3; dividend_t = 1'b1; divisor_t = 1'b1;
    start = 1'b1; start_t = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; start_t = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (quotient !== 8'd14 || quotientDone_t !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: q=%0d done_t=%b want 14 1", quotient, quotientDone_t);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({quotient, remainder, divByZero, quotientDone, quotient_t, remainder_t,
         divByZero_t, quotientDone_t} !== '0) begin
      bad++;
      $display("FAIL mid_run_reset: q=%0d r=%0d dbz=%b done=%b t=%b%b%b%b want all 0",
               quotient, remainder, divByZero, quotientDone,
               quotient_t, remainder_t, divByZero_t, quotientDone_t);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    dividend_t = 1'b0; divisor_t = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (quotientDone === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL no_done_after_reset: pulses=%0d want 0", pulses);
    end
    @(posedge clk);
    #1;
    launch(8'd9, 8'd3, 1'b0, 1'b0, 1'b0, o);
    total++;
    if (o.q !== 8'd3 || o.r !== 8'd0 || o.cyc != 10 || o.pulses != 1) begin
      bad++;
      $display("FAIL recover_9_3: q=%0d r=%0d cycle=%0d pulses=%0d want 3 0 10 1",
               o.q, o.r, o.cyc, o.pulses);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; start_t = 1'b0;
    dividend = '0; divisor = '0; dividend_t = 1'b0; divisor_t = 1'b0;
    prev_q = '0; prev_r = '0;
    test_reset();
    test_directed();
    test_ctrl_taint();
    test_random();
    test_restart_ignored();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
